// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_arb_pkg;

  // APB master phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Completion record handed back to a requester
  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/apb_rr_arb_master_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves to winner+1 only when the grant is actually used.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters starting at the pointer; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  // Rotate priority past the winner whenever a grant is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/apb_rr_arb_master.sv
// Round-robin APB master sharing one APB slave between NUM_REQ requesters.
// Optional ACCESS-phase timeout abort is enabled with `define APB_ARB_TIMEOUT_EN.
module apb_rr_arb_master
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, next_state;
  logic               any_valid;
  logic               grant_en;
  logic               complete;
  logic               abort;
  logic               tmo_hit;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] owner;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [ADDR_W-1:0]  paddr;
  logic               pwrite;
  logic [DATA_W-1:0]  pwdata;

  assign any_valid = |req_valid_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid_i),
    .en    (grant_en),
    .grant (grant),
    .idx   (grant_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] access_cnt;
  logic             rsp_err;

  // Count ACCESS cycles of the current transfer, restarting in SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      access_cnt <= '0;
    end else if (state == SETUP) begin
      access_cnt <= '0;
    end else if (state == ACCESS) begin
      access_cnt <= access_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag accompanies the response pulse; only an abort sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= abort;
    end
  end

  assign rsp_err_o = rsp_err;
`else
  assign tmo_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Phase sequencing; grants happen in IDLE or on an ACCESS completion.
  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_en   = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          complete = 1'b1;
          if (any_valid) begin
            grant_en   = 1'b1;
            next_state = SETUP;
          end else begin
            next_state = IDLE;
          end
        end else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the winner's command; it stays on the bus until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (grant_en) begin
      owner  <= grant;
      paddr  <= req_addr_i[grant_idx*ADDR_W +: ADDR_W];
      pwrite <= req_write_i[grant_idx];
      pwdata <= req_write_i[grant_idx] ? req_wdata_i[grant_idx*DATA_W +: DATA_W] : '0;
    end
  end

  // Register the slave's answer and pulse the owner's response for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (complete) begin
        rsp_valid <= owner;
        rsp_rdata <= pwrite ? '0 : prdata_i;
      end else if (abort) begin
        rsp_valid <= owner;
        rsp_rdata <= '0;
      end
    end
  end

  assign req_ready_o = grant_en ? grant : '0;
  assign rsp_valid_o = rsp_valid;
  assign rsp_rdata_o = rsp_rdata;
  assign psel_o      = (state != IDLE);
  assign penable_o   = (state == ACCESS);
  assign paddr_o     = paddr;
  assign pwrite_o    = pwrite;
  assign pwdata_o    = pwdata;

endmodule
